// File: rtl/lfsr_1.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_1
//  Brief    : Free-running Fibonacci LFSR with seed load, serial bit output,
//             step counter and period-wrap pulse.
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_1 #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             lfsr_bit,
    output logic [CNT_W-1:0] step_cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed_q;
    logic [CNT_W-1:0] r_step_cnt;
    logic             r_wrap;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    logic             w_wrap;

    assign w_fb   = ^(r_state & TAPS);
    assign w_next = {r_state[WIDTH-2:0], w_fb};
    // An all-zero seed would lock the register up, so it is replaced by 1.
    assign w_load = (seed == '0) ? c_one : seed;
    assign w_wrap = (w_next == r_seed_q);

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state    <= w_load;
            r_seed_q   <= w_load;
            r_step_cnt <= c_cnt_zero;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wrap     <= w_wrap;
            r_step_cnt <= w_wrap ? c_cnt_zero : (r_step_cnt + c_cnt_one);
        end
    end

    assign lfsr_out = r_state;
    assign lfsr_bit = r_state[WIDTH-1];
    assign step_cnt = r_step_cnt;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_1
//  Brief    : Scoreboard bench for lfsr_1 with an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_1;

    localparam int c_taps = 32'h0000B400;

    logic        clk;
    logic        resetn;
    logic [15:0] seed;
    logic [15:0] lfsr_out;
    logic        lfsr_bit;
    logic [15:0] step_cnt;
    logic        wrap;

    lfsr_1 #(.WIDTH(16), .TAPS(16'hB400), .CNT_W(16)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .seed     (seed),
        .lfsr_out (lfsr_out),
        .lfsr_bit (lfsr_bit),
        .step_cnt (step_cnt),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] st;
        logic [15:0] cnt;
        logic        wr;
        logic        rst;
        int          phase;
    } exp_t;

    exp_t sb_q[$];

    int n_checks   = 0;
    int n_failures = 0;
    int wraps_p4   = 0;
    bit seen[65536];

    // Reference model state: plain integers, step counted since the loaded seed.
    int m_state = 1;
    int m_seed  = 1;
    int m_cnt   = 0;

    function automatic int model_next(input int s);
        int ones = 0;
        for (int i = 0; i < 16; i++)
            if ((((c_taps >> i) & 1) == 1) && (((s >> i) & 1) == 1)) ones++;
        return ((s * 2) % 65536) + (ones % 2);
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
        end
    endfunction

    task automatic drive(input logic rst, input logic [15:0] s, input int ph,
                         input bit use_const, input logic [15:0] const_st);
        exp_t e;
        int   nxt;
        @(negedge clk);
        resetn = rst;
        seed   = s;
        e.wr   = 1'b0;
        if (rst) begin
            m_state = (s == 16'h0) ? 1 : int'(s);
            m_seed  = m_state;
            m_cnt   = 0;
        end else begin
            nxt     = model_next(m_state);
            e.wr    = (nxt == m_seed);
            m_cnt   = e.wr ? 0 : ((m_cnt + 1) % 65536);
            m_state = nxt;
        end
        e.st    = use_const ? const_st : 16'(m_state);
        e.cnt   = 16'(m_cnt);
        e.rst   = rst;
        e.phase = ph;
        sb_q.push_back(e);
    endtask

    // Monitor: one expectation per clock edge, checked 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk($sformatf("p%0d_lfsr_out", e.phase), int'(lfsr_out), int'(e.st));
            chk($sformatf("p%0d_step_cnt", e.phase), int'(step_cnt), int'(e.cnt));
            chk($sformatf("p%0d_wrap", e.phase), int'(wrap), int'(e.wr));
            chk($sformatf("p%0d_lfsr_bit", e.phase), int'(lfsr_bit), int'(e.st[15]));
            if (e.phase == 4) begin
                if (wrap === 1'b1) wraps_p4++;
                if (!e.rst) begin
                    chk("p4_state_nonzero", int'(lfsr_out != 16'h0), 1);
                    chk("p4_state_repeat", int'(seen[lfsr_out]), 0);
                    seen[lfsr_out] = 1'b1;
                end
            end
        end
    end

    logic [15:0] t2 [12];

    initial begin
        t2 = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
               16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801, 16'h1002};
        resetn = 1'b1;
        seed   = 16'h0001;

        // Seed 1: reset value, then the documented first 12 states.
        drive(1'b1, 16'h0001, 1, 1'b1, 16'h0001);
        for (int i = 0; i < 12; i++) drive(1'b0, 16'h0001, 2, 1'b1, t2[i]);

        // Seed 0 substitutes 1 and reproduces the same sequence.
        drive(1'b1, 16'h0000, 3, 1'b1, 16'h0001);
        for (int i = 0; i < 12; i++) drive(1'b0, 16'h0000, 3, 1'b1, t2[i]);

        // Full period from seed 1.
        drive(1'b1, 16'h0001, 4, 1'b0, 16'h0);
        for (int i = 0; i < 65535; i++) drive(1'b0, 16'h0001, 4, 1'b0, 16'h0);

        // Mid-run reload, then seed churn while running.
        for (int i = 0; i < 100; i++) drive(1'b0, 16'(i), 5, 1'b0, 16'h0);
        drive(1'b1, 16'hACE1, 5, 1'b1, 16'hACE1);
        for (int i = 0; i < 200; i++) drive(1'b0, 16'($urandom), 5, 1'b0, 16'h0);

        // Seed 1, 256 steps.
        drive(1'b1, 16'h0001, 6, 1'b0, 16'h0);
        for (int i = 0; i < 256; i++) drive(1'b0, 16'h0001, 6, 1'b0, 16'h0);

        // Random resets and seeds.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [15:0] s;
            r = ($urandom_range(0, 49) == 0) || (i == 0);
            s = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            drive(r, s, 7, 1'b0, 16'h0);
        end

        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("p4_wrap_count", wraps_p4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
`default_nettype wire
